d_reg_bank: RTL and testbench
=============================

# d_reg_bank

Parametrised, clocked successor to the gate-level D latch. It holds CHANNELS independent WIDTH-bit registers. Each channel has its own enable, a shared 2-bit mode (hold, load, shift-left, shift-right), complementary outputs, and a registered per-channel change flag. It is the team's general-purpose storage/shift stage for datapath and test-bench building blocks.

## Interface
Parameters:
- WIDTH, default 8: bits per channel, must be at least 2.
- CHANNELS, default 4: number of independent channels, must be at least 1.

Ports:
- clk, input, 1: rising-edge clock, the only clock.
- rst, input, 1: synchronous reset, active-high.
- en, input, CHANNELS: per-channel update enable.
- mode, input, 2: 00 hold, 01 load, 10 shift-left, 11 shift-right. Shared by all channels.
- ser_in, input, CHANNELS: serial input bit per channel, used in the shift modes.
- d, input, CHANNELS*WIDTH: parallel data. Channel i occupies d[i*WIDTH +: WIDTH].
- q, output, CHANNELS*WIDTH: registered state, same packing as d.
- qbar, output, CHANNELS*WIDTH: bitwise complement of q at all times.
- changed, output, CHANNELS: registered flag. changed[i] = 1 when channel i's q changed value on the last edge.
- parity, output, CHANNELS: present only when REG_BANK_PARITY_EN is defined (see Configuration).

## Operation
- All state updates happen on the rising edge of clk. There are no latches and no combinational paths from inputs to q.
- Reset (rst = 1 at an edge) clears every channel: q = 0, qbar = all ones, changed = 0, parity = 0.
- rst has priority over en and mode.
- For each channel i where en[i] = 1 at the edge:
  - mode 00: q_i is unchanged.
  - mode 01: q_i <= d_i.
  - mode 10: q_i <= {q_i[WIDTH-2:0], ser_in[i]}. The MSB is discarded.
  - mode 11: q_i <= {ser_in[i], q_i[WIDTH-1:1]}. The LSB is discarded.
- A channel with en[i] = 0 holds its value regardless of mode.
- changed[i] <= (next q_i != current q_i). This is evaluated independently per channel and is 0 whenever the channel holds.
- A load with d_i equal to the current q_i gives changed[i] = 0.
- qbar is ~q and is driven continuously. No output ever shows the invalid q == qbar state.
- Mode values are fully decoded. There is no illegal encoding.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on q, qbar, changed (and parity) after edge N.
- changed is a one-cycle pulse per update. Back-to-back changing updates keep it high on consecutive cycles.
- Reset mid-shift abandons the shift: the state is 0 after that edge. Normal operation resumes on the first edge with rst = 0.
- Channels are fully independent. Enabling any subset in the same cycle is legal and updates only that subset.
- After reset, q stays 0 with changed = 0 until the first enabled, value-changing edge.

## Configuration
- REG_BANK_PARITY_EN:
  - Defined: the parity output exists. parity[i] is registered and equals ^q_i (even-parity bit of the channel's new value), updated on the same edge as q_i, and cleared to 0 by reset.
  - Undefined: the parity port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package d_reg_pkg holds:
  - mode constants: MODE_HOLD = 2'b00, MODE_LOAD = 2'b01, MODE_SHL = 2'b10, MODE_SHR = 2'b11;
  - the mode typedef.
- Sub-module d_reg_cell: one WIDTH-bit channel containing its next-state mux, change comparator and optional parity flop. It is instantiated CHANNELS times by a generate loop in d_reg_bank.
- The top level only slices the buses and fans out clk, rst and mode.

## Test plan
All scenarios use WIDTH = 8 and CHANNELS = 4.
- Reset: rst = 1 for 2 cycles with random d/en/mode -> q = 0, qbar = 0xFF per channel, changed = 0000.
- Load: en = 1111, mode = 01, d = {0xA5, 0x3C, 0xFF, 0x00} -> after 1 edge q matches d and changed = 1110 (the channel loading 0x00 does not change).
- Shift:
  - channel 0 q = 0x81, mode = 10, ser_in[0] = 1 -> q0 = 0x03;
  - next edge with mode = 11, ser_in[0] = 0 -> q0 = 0x01.
- Enable masking: en = 0101, mode = 01, d all 0x55 -> only channels 0 and 2 read 0x55, channels 1 and 3 hold; changed = 0101 for one cycle, then 0000 when en = 0000.
- Reset mid-operation: rst asserted during a shift sequence on 0xF0 -> q = 0 next cycle. Release rst, load 0x0F -> q = 0x0F and changed = 1.
- With REG_BANK_PARITY_EN defined: load 0x07 -> parity = 1; load 0x03 -> parity = 0; rst -> parity = 0.

Source files
------------

// File: rtl/d_reg_pkg.sv
// d_reg_pkg: mode encoding shared by the register bank, its cells and its interface.
package d_reg_pkg;
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_t;
endpackage

// File: rtl/d_reg_bank_if.sv
// d_reg_bank_if: data/control bundle of the register bank; parity exists only under REG_BANK_PARITY_EN.
interface d_reg_bank_if
    import d_reg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       en;
    mode_t                     mode;
    logic [CHANNELS-1:0]       ser_in;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [CHANNELS*WIDTH-1:0] qbar;
    logic [CHANNELS-1:0]       changed;
`ifdef REG_BANK_PARITY_EN
    logic [CHANNELS-1:0]       parity;
    modport master (output en, mode, ser_in, d, input q, qbar, changed, parity);
    modport slave  (input en, mode, ser_in, d, output q, qbar, changed, parity);
`else
    modport master (output en, mode, ser_in, d, input q, qbar, changed);
    modport slave  (input en, mode, ser_in, d, output q, qbar, changed);
`endif
endinterface

// File: rtl/d_reg_cell.sv
// d_reg_cell: one WIDTH-bit channel with load/shift next-state mux, change flag and
// an optional parity flop (REG_BANK_PARITY_EN).
module d_reg_cell
    import d_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  mode_t            i_mode,
    input  logic             i_ser,
    input  logic [WIDTH-1:0] i_d,
`ifdef REG_BANK_PARITY_EN
    output logic             o_parity,
`endif
    output logic [WIDTH-1:0] o_q,
    output logic             o_changed
);
    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = !i_en                ? r_q :
                 i_mode == MODE_LOAD  ? i_d :
                 i_mode == MODE_SHL   ? {r_q[WIDTH-2:0], i_ser} :
                 i_mode == MODE_SHR   ? {i_ser, r_q[WIDTH-1:1]} : r_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_changed <= 1'b0;
        end else begin
            r_q       <= w_next;
            r_changed <= w_next != r_q;
        end
    end

`ifdef REG_BANK_PARITY_EN
    logic r_parity;
    always_ff @(posedge clk) begin
        if (rst) r_parity <= 1'b0;
        else     r_parity <= ^w_next;
    end
    assign o_parity = r_parity;
`endif

    assign o_q       = r_q;
    assign o_changed = r_changed;
endmodule

// File: rtl/d_reg_bank.sv
// d_reg_bank: CHANNELS independent WIDTH-bit hold/load/shift registers with complementary
// outputs and change flags; parity output enabled by REG_BANK_PARITY_EN.
module d_reg_bank
    import d_reg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input logic         clk,
    input logic         rst,
    d_reg_bank_if.slave bus
);
    logic [CHANNELS*WIDTH-1:0] w_q;
    logic [CHANNELS-1:0]       w_changed;
`ifdef REG_BANK_PARITY_EN
    logic [CHANNELS-1:0]       w_parity;
    assign bus.parity = w_parity;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        d_reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk      (clk),
            .rst      (rst),
            .i_en     (bus.en[i]),
            .i_mode   (bus.mode),
            .i_ser    (bus.ser_in[i]),
            .i_d      (bus.d[i*WIDTH +: WIDTH]),
`ifdef REG_BANK_PARITY_EN
            .o_parity (w_parity[i]),
`endif
            .o_q      (w_q[i*WIDTH +: WIDTH]),
            .o_changed(w_changed[i])
        );
    end

    assign bus.q       = w_q;
    assign bus.qbar    = ~w_q;
    assign bus.changed = w_changed;
endmodule

// File: tb/tb_d_reg_bank.sv
// tb_d_reg_bank: directed scenarios plus random traffic against a per-channel byte model.
module tb_d_reg_bank;
    import d_reg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mq [4];
    logic [3:0] mc;
    logic [3:0] mp;

    always #5 clk = ~clk;

    d_reg_bank_if #(.WIDTH(8), .CHANNELS(4)) bus ();

    d_reg_bank #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_q();
        return {mq[3], mq[2], mq[1], mq[0]};
    endfunction

    task automatic step(input string tag, input logic r, input logic [3:0] e,
                        input logic [1:0] m, input logic [3:0] s, input logic [31:0] dv);
        logic [7:0] nxt;
        rst        = r;
        bus.en     = e;
        bus.mode   = mode_t'(m);
        bus.ser_in = s;
        bus.d      = dv;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (r) nxt = 8'h00;
            else if (!e[i]) nxt = mq[i];
            else case (m)
                2'd1:    nxt = dv[i*8 +: 8];
                2'd2:    nxt = 8'((mq[i] * 2) + s[i]);
                2'd3:    nxt = (mq[i] / 2) + (s[i] ? 8'h80 : 8'h00);
                default: nxt = mq[i];
            endcase
            mc[i] = !r && (nxt != mq[i]);
            mp[i] = ^nxt;
            mq[i] = nxt;
        end
        #1;
        chk({tag, "_q"}, bus.q, exp_q());
        chk({tag, "_qbar"}, bus.qbar, ~exp_q());
        chk({tag, "_chg"}, {28'd0, bus.changed}, {28'd0, mc});
`ifdef REG_BANK_PARITY_EN
        chk({tag, "_par"}, {28'd0, bus.parity}, {28'd0, mp});
`endif
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mq[i] = 8'h00;
        mc = '0;
        mp = '0;
        bus.en = '0; bus.mode = MODE_HOLD; bus.ser_in = '0; bus.d = '0;
        repeat (2) step("rst", 1'b1, 4'($urandom), 2'($urandom), 4'($urandom), $urandom);
        chk("rst_q_const", bus.q, 32'h0);
        chk("rst_qbar_const", bus.qbar, 32'hFFFF_FFFF);

        step("load", 1'b0, 4'b1111, 2'd1, 4'h0, 32'hA53C_FF00);
        chk("load_q_const", bus.q, 32'hA53C_FF00);
        chk("load_chg_const", {28'd0, bus.changed}, 32'b1110);

        step("ld81", 1'b0, 4'b0001, 2'd1, 4'h0, 32'h0000_0081);
        step("shl", 1'b0, 4'b0001, 2'd2, 4'b0001, 32'h0);
        chk("shl_const", {24'd0, bus.q[7:0]}, 32'h03);
        step("shr", 1'b0, 4'b0001, 2'd3, 4'b0000, 32'h0);
        chk("shr_const", {24'd0, bus.q[7:0]}, 32'h01);

        step("ld00", 1'b0, 4'b1111, 2'd1, 4'h0, 32'h0);
        step("mask", 1'b0, 4'b0101, 2'd1, 4'h0, 32'h5555_5555);
        chk("mask_q_const", bus.q, 32'h0055_0055);
        chk("mask_chg_const", {28'd0, bus.changed}, 32'b0101);
        step("idle", 1'b0, 4'b0000, 2'd1, 4'hF, 32'hFFFF_FFFF);
        chk("idle_chg_const", {28'd0, bus.changed}, 32'b0000);

        step("ldF0", 1'b0, 4'b1111, 2'd1, 4'h0, 32'hF0F0_F0F0);
        step("shf", 1'b0, 4'b1111, 2'd2, 4'hF, 32'h0);
        step("mrst", 1'b1, 4'b1111, 2'd2, 4'hF, 32'h0);
        chk("mrst_const", bus.q, 32'h0);
        step("ld0F", 1'b0, 4'b1111, 2'd1, 4'h0, 32'h0F0F_0F0F);
        chk("ld0F_chg_const", {28'd0, bus.changed}, 32'b1111);

        step("p07", 1'b0, 4'b0001, 2'd1, 4'h0, 32'h0000_0007);
        step("p03", 1'b0, 4'b0001, 2'd1, 4'h0, 32'h0000_0003);
        step("prst", 1'b1, 4'b0000, 2'd0, 4'h0, 32'h0);

        for (int k = 0; k < 300; k++)
            step("rnd", ($urandom_range(0, 19) == 0), 4'($urandom), 2'($urandom),
                 4'($urandom), $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
